// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter with width reduction, stepped volume and optional saturating mono mix.
// Define AUDIO_I2S_TX_PHILIPS_EN for Philips format (din one BCK behind ws); default is left-justified.
module audio_i2s_tx #(
    parameter int IN_W       = 18,
    parameter int SAMPLE_W   = 16,
    parameter int STEREO     = 1,
    parameter int MONO_SHIFT = 3,
    parameter int VOL_W      = 2,
    parameter int DIV_W      = 8,
    parameter int AMP_POL    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] bck_div,
    input  logic [VOL_W-1:0] volume,
    input  logic             amp_enable,
    input  logic [IN_W-1:0]  audio_l,
    input  logic [IN_W-1:0]  audio_r,
    output logic             i2s_bck,
    output logic             i2s_ws,
    output logic             i2s_din,
    output logic             amp_en,
    output logic             frame_strobe,
    output logic             clip
);
    localparam int CW = $clog2(2*SAMPLE_W);
    localparam logic AMP_ON = (AMP_POL != 0);

    logic signed [SAMPLE_W-1:0] red_l, red_r, sh_l, sh_r, vol_l, vol_r, mix_l, mix_r, proc_l, proc_r;
    logic signed [SAMPLE_W:0]   sum, avg;
    logic                       sat, proc_sat, head, fall;
    logic [DIV_W-1:0]           div_cnt;
    logic [CW-1:0]              bit_cnt, nb;
    logic [2*SAMPLE_W-2:0]      sr;

    // shift amount ~volume equals 2^VOL_W-1-volume
    always_comb begin
        sh_l  = red_l >>> ~volume;
        sh_r  = red_r >>> ~volume;
        vol_l = (volume == '0) ? '0 : sh_l;
        vol_r = (volume == '0) ? '0 : sh_r;
        sum   = {vol_l[SAMPLE_W-1], vol_l} + {vol_r[SAMPLE_W-1], vol_r};
        avg   = sum >>> MONO_SHIFT;
        sat   = avg[SAMPLE_W] != avg[SAMPLE_W-1];
        mix_l = (STEREO != 0) ? vol_l :
                sat ? {avg[SAMPLE_W], {(SAMPLE_W-1){~avg[SAMPLE_W]}}} : avg[SAMPLE_W-1:0];
        mix_r = (STEREO != 0) ? vol_r : mix_l;
        nb    = (bit_cnt == CW'(2*SAMPLE_W-1)) ? '0 : bit_cnt + 1'b1;
        fall  = (div_cnt >= bck_div) && i2s_bck;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_l        <= '0;
            red_r        <= '0;
            proc_l       <= '0;
            proc_r       <= '0;
            proc_sat     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '1;
            {head, sr}   <= '0;
            i2s_bck      <= 1'b0;
            i2s_ws       <= 1'b0;
            frame_strobe <= 1'b0;
            clip         <= 1'b0;
            amp_en       <= ~AMP_ON;
        end else begin
            red_l        <= audio_l[IN_W-1 -: SAMPLE_W];
            red_r        <= audio_r[IN_W-1 -: SAMPLE_W];
            proc_l       <= mix_l;
            proc_r       <= mix_r;
            proc_sat     <= (STEREO == 0) && sat;
            amp_en       <= amp_enable ? AMP_ON : ~AMP_ON;
            frame_strobe <= 1'b0;
            clip         <= 1'b0;
            if (div_cnt >= bck_div) begin
                div_cnt <= '0;
                i2s_bck <= ~i2s_bck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt      <= nb;
                i2s_ws       <= nb >= CW'(SAMPLE_W);
                {head, sr}   <= (nb == '0) ? {proc_l, proc_r} : {sr, 1'b0};
                frame_strobe <= nb == '0;
                clip         <= (nb == '0) && proc_sat;
            end
        end
    end

`ifdef AUDIO_I2S_TX_PHILIPS_EN
    always_ff @(posedge clk)
        i2s_din <= reset ? 1'b0 : fall ? head : i2s_din;
`else
    assign i2s_din = head;
`endif

    if (IN_W > SAMPLE_W) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^{audio_l[IN_W-SAMPLE_W-1:0], audio_r[IN_W-SAMPLE_W-1:0]};
    end
endmodule
